// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types for the register-file writeback path.
package regfile_pkg;
   localparam int NUM_REGS  = 16;
   localparam int WB_DATA_W = 16;
   typedef logic [3:0] reg_id_t;
   typedef struct packed {
      reg_id_t                rd;
      logic [WB_DATA_W-1:0]   data;
   } wb_req_t;
   typedef enum logic {REQ_EX, REQ_MEM} req_e;
endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_fifo: small synchronous FIFO of writeback requests.
module wb_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push_i,
   input  logic    pop_i,
   input  wb_req_t din_i,
   output logic    full_o,
   output logic    empty_o,
   output wb_req_t head_o
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   wb_req_t        mem_q [DEPTH];
   logic [AW-1:0]  rd_q, wr_q;
   logic [CW-1:0]  cnt_q;
   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
   endfunction
   assign full_o  = cnt_q == CW'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign head_o  = mem_q[rd_q];
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= din_i;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= nxt(wr_q);
         if (pop_i) rd_q <= nxt(rd_q);
         cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the register-file write port
// between EX and MEM writeback queues, with a per-register pending scoreboard.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [3:0]        ex_reg,
   input  logic [DATA_W-1:0] ex_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [3:0]        mem_reg,
   input  logic [DATA_W-1:0] mem_data,
   output logic [3:0]        DstReg,
   output logic              WriteReg,
   output logic [DATA_W-1:0] DstData,
   output logic [15:0]       pend_mask
);
   localparam int CW = $clog2(2 * FIFO_DEPTH + 2);
   logic        ex_full, ex_empty, mem_full, mem_empty;
   logic        ex_push, mem_push, grant_ex, grant_mem, same;
   wb_req_t     ex_head, mem_head, win;
   req_e        ptr_q, ptr_d;
   reg_id_t     dst_reg_q;
   logic        write_reg_q;
   logic [DATA_W-1:0] dst_data_q;
   logic [CW-1:0] cnt_q [NUM_REGS];
   logic [CW-1:0] cnt_d [NUM_REGS];
   assign ex_ready  = !ex_full;
   assign mem_ready = !mem_full;
   assign ex_push   = ex_valid && ex_ready;
   assign mem_push  = mem_valid && mem_ready;
   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_ex_fifo (
      .clk(clk), .rst(rst), .push_i(ex_push), .pop_i(grant_ex),
      .din_i('{rd: ex_reg, data: WB_DATA_W'(ex_data)}),
      .full_o(ex_full), .empty_o(ex_empty), .head_o(ex_head)
   );
   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
      .clk(clk), .rst(rst), .push_i(mem_push), .pop_i(grant_mem),
      .din_i('{rd: mem_reg, data: WB_DATA_W'(mem_data)}),
      .full_o(mem_full), .empty_o(mem_empty), .head_o(mem_head)
   );
   // MEM holds the older instruction, so it wins a same-register collision.
   always_comb begin
      same      = !ex_empty && !mem_empty && ex_head.rd == mem_head.rd && ex_head.rd != '0;
      grant_mem = !mem_empty && (ex_empty || same || ptr_q == REQ_MEM);
      grant_ex  = !ex_empty && !grant_mem;
      win       = grant_mem ? mem_head : ex_head;
      ptr_d     = grant_mem ? REQ_EX : grant_ex ? REQ_MEM : ptr_q;
   end
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = cnt_q[r] + CW'(ex_push && ex_reg == reg_id_t'(r))
                             + CW'(mem_push && mem_reg == reg_id_t'(r))
                             - CW'(write_reg_q && dst_reg_q == reg_id_t'(r));
      end
      cnt_d[0] = '0;
   end
   always_comb begin
      pend_mask = '0;
      for (int r = 1; r < NUM_REGS; r++) pend_mask[r] = cnt_q[r] != '0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q       <= REQ_MEM;
         dst_reg_q   <= '0;
         write_reg_q <= 1'b0;
         dst_data_q  <= '0;
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      end else begin
         ptr_q       <= ptr_d;
         write_reg_q <= (grant_ex || grant_mem) && win.rd != '0;
         if (grant_ex || grant_mem) begin
            dst_reg_q  <= win.rd;
            dst_data_q <= DATA_W'(win.data);
         end
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      end
   end
   assign DstReg   = dst_reg_q;
   assign WriteReg = write_reg_q;
   assign DstData  = dst_data_q;
endmodule
